// File: rtl/vedic_mul8_seq.sv
// Sequential 8x8 unsigned multiplier. A single shared vedic_4x4 core is
// time-multiplexed over four partial-product steps. The partial products
// are accumulated into a 16-bit product, and operands and result move over
// valid/ready handshakes.

// 2x2 Vedic (Urdhva Tiryakbhyam) multiplier built from two half adders.
module vedic_2x2 (
    input  logic [1:0] a,
    input  logic [1:0] b,
    output logic [3:0] p
);
    logic w_t1, w_t2, w_t3, w_s1, w_c1, w_s2, w_c2;

    // Vertical and crosswise products, with their carries rippled upward.
    always_comb begin
        w_t1 = a[1] & b[0];
        w_t2 = a[0] & b[1];
        w_s1 = w_t1 ^ w_t2;
        w_c1 = w_t1 & w_t2;
        w_t3 = a[1] & b[1];
        w_s2 = w_t3 ^ w_c1;
        w_c2 = w_t3 & w_c1;
        p    = {w_c2, w_s2, w_s1, a[0] & b[0]};
    end
endmodule

// 4x4 Vedic multiplier composed of four 2x2 blocks.
module vedic_4x4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [7:0] p
);
    logic [3:0] w_q0, w_q1, w_q2, w_q3;

    vedic_2x2 u_q0 (.a(a[1:0]), .b(b[1:0]), .p(w_q0));
    vedic_2x2 u_q1 (.a(a[3:2]), .b(b[1:0]), .p(w_q1));
    vedic_2x2 u_q2 (.a(a[1:0]), .b(b[3:2]), .p(w_q2));
    vedic_2x2 u_q3 (.a(a[3:2]), .b(b[3:2]), .p(w_q3));

    // Combine the four quadrant products. The maximum is 225, so 8 bits cannot overflow.
    always_comb begin
        p = {4'b0000, w_q0} + {2'b00, w_q1, 2'b00}
          + {2'b00, w_q2, 2'b00} + {w_q3, 4'b0000};
    end
endmodule

module vedic_mul8_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] result,
    output logic        busy
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]  r_state;
    logic [1:0]  r_step;
    logic [7:0]  r_a;
    logic [7:0]  r_b;
    logic [15:0] r_acc;
    logic        r_out_valid;

    logic [3:0]  w_op_a;
    logic [3:0]  w_op_b;
    logic [7:0]  w_pp;
    logic [15:0] w_pp_shift;

    // Step bit 0 selects the a nibble and step bit 1 selects the b nibble.
    always_comb begin
        w_op_a = r_step[0] ? r_a[7:4] : r_a[3:0];
        w_op_b = r_step[1] ? r_b[7:4] : r_b[3:0];
    end

    vedic_4x4 u_core (.a(w_op_a), .b(w_op_b), .p(w_pp));

    // Place the partial product at its weight: lo*lo=0, cross terms=4, hi*hi=8.
    always_comb begin
        case (r_step)
            2'd0:    w_pp_shift = {8'h00, w_pp};
            2'd1:    w_pp_shift = {4'h0, w_pp, 4'h0};
            2'd2:    w_pp_shift = {4'h0, w_pp, 4'h0};
            2'd3:    w_pp_shift = {w_pp, 8'h00};
            default: w_pp_shift = 16'h0000;
        endcase
    end

    // Control FSM, operand capture and accumulation. Reset overrides any handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_step      <= 2'd0;
            r_a         <= 8'h00;
            r_b         <= 8'h00;
            r_acc       <= 16'h0000;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_acc   <= 16'h0000;
                        r_step  <= 2'd0;
                        r_state <= S_MUL;
                    end
                end
                S_MUL: begin
                    r_acc  <= r_acc + w_pp_shift;
                    r_step <= r_step + 2'd1;
                    if (r_step == 2'd3) begin
                        r_state     <= S_DONE;
                        r_out_valid <= 1'b1;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_state     <= S_IDLE;
                        r_out_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_step      <= 2'd0;
                    r_acc       <= 16'h0000;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    // Status outputs are decoded from state registers only.
    always_comb begin
        in_ready  = (r_state == S_IDLE);
        busy      = (r_state != S_IDLE);
        out_valid = r_out_valid;
        result    = r_acc;
    end
endmodule

// File: doc/vedic_mul8_seq.md
# vedic_mul8_seq

Sequential 8x8 unsigned multiplier built around a single shared `vedic_4x4` instance. It time-multiplexes the 4x4 core over four partial-product steps and accumulates them into a 16-bit product. Operands enter and the product leaves over valid/ready handshakes. It sits between operand-producing logic and result consumers wherever the area of a full combinational 8x8 Vedic tree is not affordable.

## Interface
- Parameters: none.
- `clk` in 1: single clock; all state updates on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: operand pair `a`/`b` is presented.
- `in_ready` out 1: block can accept operands (high only in IDLE).
- `a` in 8: multiplicand, unsigned.
- `b` in 8: multiplier, unsigned.
- `out_valid` out 1: `result` holds a completed product.
- `out_ready` in 1: consumer accepts `result`.
- `result` out 16: product a*b, unsigned.
- `busy` out 1: high in MUL or DONE.

## Operation
- One `vedic_4x4` instance. Its operand muxes are driven from the registered operands `a_r`/`b_r` and the step counter `step[1:0]`.
- Step mapping, as (4x4 operands, left shift applied to the 8-bit partial product):
  - step 0: `a_r[3:0]`, `b_r[3:0]`, shift 0
  - step 1: `a_r[7:4]`, `b_r[3:0]`, shift 4
  - step 2: `a_r[3:0]`, `b_r[7:4]`, shift 4
  - step 3: `a_r[7:4]`, `b_r[7:4]`, shift 8
- Accumulator `acc` is 16 bits. Each MUL cycle does `acc <= acc + (pp << shift)`, with the shifted partial product zero-extended to 16 bits.
  - The sum never exceeds 0xFE01, so no carry out of bit 15 can occur. No saturation or overflow flag.
- `result` is driven directly from `acc`.
- FSM states and transitions:
  - IDLE: `in_ready`=1. On `in_valid & in_ready`: latch `a_r`<=`a`, `b_r`<=`b`, `acc`<=0, `step`<=0, go to MUL.
  - MUL: `in_ready`=0. Accumulate the current step, then `step`<=`step`+1. When `step`==3, go to DONE.
  - DONE: `out_valid`=1; `result` is stable. On `out_valid & out_ready`: go to IDLE. Otherwise hold all state.
- While not in IDLE, `in_valid` is ignored. `a`/`b` may change freely; only the values latched at accept are used.
- `out_ready` is ignored outside DONE.
- `busy` = (state != IDLE).
- No pipelining: at most one operation is in flight.

## Timing
- Reset: takes effect at the first rising edge with `rst`=1. Values held while `rst` is high:
  - state=IDLE, `step`=0, `acc`=0, `a_r`=0, `b_r`=0
  - `result`=0x0000, `out_valid`=0, `busy`=0, `in_ready`=1
- Reset mid-operation (in MUL or DONE) aborts the operation: no `out_valid` is produced for it, and the accumulator is cleared.
- Reset has priority over every handshake sampled at the same edge.
- Accept at edge E0 means the MUL steps accumulate at edges E1 through E4. `out_valid` rises after E4, giving 4 cycles from accept edge to `out_valid`.
- Output handshake at edge Ek (k≥5): the block is in IDLE after Ek, and the next accept can occur at Ek+1 at the earliest.
- Best-case throughput: one product per 6 cycles, with `out_ready` held high.
- `result` and `out_valid` are registered outputs, with no combinational path from inputs.
- `in_ready` and `busy` are decoded from the state register only. They do not depend combinationally on `in_valid` or `out_ready`.
- Backpressure: with `out_ready` low, DONE holds indefinitely and `result` does not change.

## Test plan
- Reset, then `a`=0x12, `b`=0x34 with `in_valid` for 1 cycle -> `in_ready` falls, then 4 cycles later `out_valid`=1 with `result`=0x03A8, `busy`=1 until the output handshake.
- Corner values: 0xFF*0xFF -> 0xFE01, 0x00*0x5A -> 0x0000, 0xA7*0x3C -> 0x2724, 0x01*0xFF -> 0x00FF, 0x80*0x80 -> 0x4000.
- Backpressure: hold `out_ready`=0 for 10 cycles after `out_valid` -> `result` is stable at the product and `out_valid` stays 1. Raise `out_ready` -> one transfer, then IDLE and `in_ready`=1 the next cycle.
- Busy-input rejection: start 0x0F*0x0F, then drive `in_valid`=1 with 0xFF/0xFF and toggling `a`/`b` during MUL -> `result`=0x00E1 only, and exactly one `out_valid` transfer.
- Reset mid-op: assert `rst` for 1 cycle at step 2 -> `out_valid` never rises for that op, `result`=0, `in_ready`=1 after reset. A following 0x03*0x05 gives 0x000F.
- Back-to-back random: 1000 random pairs with random `in_valid`/`out_ready` gaps -> every product matches a*b, in order, with no drops or duplicates.
